fll_trim_ctrl: RTL and testbench



---
 rtl/fll_trim_ctrl_if.sv | 27 ++
 rtl/fll_trim_ctrl.sv | 163 ++++++++++++++++
 tb/tb_fll_trim_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/fll_trim_ctrl_if.sv
// fll_trim_ctrl_if: control, feedback and trim bundle of the FLL controller.
// master: enable/div/dco/ext_trim/fb_count/fb_valid out; trim/locked/fb_lost in.
interface fll_trim_ctrl_if #(
  parameter int TRIM_W = 26,
  parameter int DIV_W  = 5,
  parameter int CNT_W  = 8
);
  logic              enable;
  logic [DIV_W-1:0]  div;
  logic              dco;
  logic [TRIM_W-1:0] ext_trim;
  logic [CNT_W-1:0]  fb_count;
  logic              fb_valid;
  logic [TRIM_W-1:0] trim;
  logic              locked;
  logic              fb_lost;

  modport master (
    output enable, div, dco, ext_trim, fb_count, fb_valid,
    input  trim, locked, fb_lost
  );

  modport slave (
    input  enable, div, dco, ext_trim, fb_count, fb_valid,
    output trim, locked, fb_lost
  );
endinterface

// File: rtl/fll_trim_ctrl.sv
// fll_trim_ctrl: FLL frequency-lock controller, thermometer DCO trim.
// osc/reset (sync, active-high) plus slave bus: trim, locked, fb_lost out.
module fll_trim_ctrl #(
  parameter int TRIM_W      = 26,
  parameter int DIV_W       = 5,
  parameter int CNT_W       = 8,
  parameter int COARSE_THR  = 4,
  parameter int COARSE_STEP = 4,
  parameter int LOCK_TOL    = 1,
  parameter int LOCK_CNT    = 4,
  parameter int TIMEOUT     = 1024
) (
  input  logic           osc,
  input  logic           reset,
  fll_trim_ctrl_if.slave bus
);
  localparam int CODE_W  = $clog2(TRIM_W + 1);
  localparam int CODE_W1 = CODE_W + 1;
  localparam int ERR_W   = ((CNT_W > DIV_W) ? CNT_W : DIV_W) + 1;
  localparam int WIN_W   = $clog2(LOCK_CNT + 1);
  localparam int TO_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] MANUAL  = 2'd1;
  localparam logic [1:0] ACQUIRE = 2'd2;
  localparam logic [1:0] LOCKED  = 2'd3;

  localparam logic [CODE_W-1:0] MID    = CODE_W'(TRIM_W / 2);
  localparam logic [CODE_W-1:0] CSTEP  = CODE_W'(COARSE_STEP);
  localparam logic [CODE_W:0]   TOP    = CODE_W1'(TRIM_W);
  localparam logic [ERR_W-1:0]  THR    = ERR_W'(COARSE_THR);
  localparam logic [ERR_W-1:0]  TOL    = ERR_W'(LOCK_TOL);
  localparam logic [ERR_W-1:0]  TOL2   = ERR_W'(2 * LOCK_TOL);
  localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(LOCK_CNT - 1);
  localparam logic [TO_W-1:0]   TO_MAX = TO_W'(TIMEOUT - 1);

  function automatic logic [TRIM_W-1:0] therm(
    input logic [CODE_W-1:0] c
  );
    logic [TRIM_W-1:0] t;
    for (int i = 0; i < TRIM_W; i++) t[i] = (i < int'(c));
    return t;
  endfunction

  logic [1:0]        state, state_n;
  logic [CODE_W-1:0] code, code_n;
  logic [WIN_W-1:0]  win_cnt, win_n;
  logic [TO_W-1:0]   to_cnt, to_n;
  logic              locked_q, locked_n;
  logic              lost_q, lost_n;
  logic [TRIM_W-1:0] trim_q, trim_n;

  logic [ERR_W-1:0]  err, err_mag;
  logic [CODE_W-1:0] step, inc_code, dec_code;
  logic [CODE_W:0]   sum;
  logic              hit;

  // err is two's complement; its MSB is the sign
  assign err     = ERR_W'(bus.fb_count) - ERR_W'(bus.div);
  assign err_mag = err[ERR_W-1] ? -err : err;
  assign step    = (state == ACQUIRE && err_mag > THR) ? CSTEP
                                                       : CODE_W'(1);
  assign sum      = {1'b0, code} + {1'b0, step};
  assign inc_code = (sum > TOP) ? TOP[CODE_W-1:0] : sum[CODE_W-1:0];
  assign dec_code = (code < step) ? '0 : code - step;
  // div=0 has no meaningful target, so strobes are dropped
  assign hit = bus.fb_valid && (bus.div != '0);

  always_comb begin
    state_n  = state;
    code_n   = code;
    win_n    = win_cnt;
    to_n     = to_cnt;
    locked_n = locked_q;
    lost_n   = lost_q;
    if (!bus.enable) begin
      state_n  = IDLE;
      code_n   = MID;
      win_n    = '0;
      to_n     = '0;
      locked_n = 1'b0;
      lost_n   = 1'b0;
    end else begin
      unique case (state)
        IDLE: state_n = bus.dco ? MANUAL : ACQUIRE;
        MANUAL: begin
          if (!bus.dco) begin
            state_n = ACQUIRE;
            win_n   = '0;
            to_n    = '0;
          end
        end
        default: begin
          if (bus.dco) begin
            state_n  = MANUAL;
            locked_n = 1'b0;
          end else if (hit) begin
            to_n   = '0;
            lost_n = 1'b0;
            if (err[ERR_W-1])   code_n = inc_code;
            else if (err != '0) code_n = dec_code;
            if (state == ACQUIRE) begin
              if (err_mag <= TOL) begin
                if (win_cnt == WIN_LAST) begin
                  state_n  = LOCKED;
                  locked_n = 1'b1;
                  win_n    = '0;
                end else begin
                  win_n = win_cnt + WIN_W'(1);
                end
              end else begin
                win_n = '0;
              end
            end else if (err_mag > TOL2) begin
              state_n  = ACQUIRE;
              locked_n = 1'b0;
              win_n    = '0;
            end
          end else begin
            if (bus.div == '0) begin
              state_n  = ACQUIRE;
              locked_n = 1'b0;
            end
            if (to_cnt == TO_MAX) begin
              state_n  = ACQUIRE;
              lost_n   = 1'b1;
              locked_n = 1'b0;
              win_n    = '0;
              to_n     = '0;
            end else begin
              to_n = to_cnt + TO_W'(1);
            end
          end
        end
      endcase
    end
    trim_n = (state_n == MANUAL) ? bus.ext_trim : therm(code_n);
  end

  always_ff @(posedge osc) begin
    if (reset) begin
      state    <= IDLE;
      code     <= MID;
      win_cnt  <= '0;
      to_cnt   <= '0;
      locked_q <= 1'b0;
      lost_q   <= 1'b0;
      trim_q   <= therm(MID);
    end else begin
      state    <= state_n;
      code     <= code_n;
      win_cnt  <= win_n;
      to_cnt   <= to_n;
      locked_q <= locked_n;
      lost_q   <= lost_n;
      trim_q   <= trim_n;
    end
  end

  assign bus.trim    = trim_q;
  assign bus.locked  = locked_q;
  assign bus.fb_lost = lost_q;
endmodule

// File: tb/tb_fll_trim_ctrl.sv
// tb_fll_trim_ctrl: scoreboard bench for fll_trim_ctrl, directed vectors.
// Stimulus queues expected outputs; a monitor compares after each edge.
module tb_fll_trim_ctrl;
  logic osc;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  fll_trim_ctrl_if #(.TRIM_W(26), .DIV_W(5), .CNT_W(8)) bus ();

  fll_trim_ctrl #(
    .TRIM_W(26), .DIV_W(5), .CNT_W(8),
    .COARSE_THR(4), .COARSE_STEP(4),
    .LOCK_TOL(1), .LOCK_CNT(4), .TIMEOUT(1024)
  ) dut (
    .osc  (osc),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    osc = 1'b0;
    forever #5 osc = ~osc;
  end

  always @(posedge osc) cyc <= cyc + 1;

  typedef struct packed {
    int          due;
    logic [25:0] trim;
    logic        locked;
    logic        lost;
  } exp_t;

  exp_t  q[$];
  string names[$];
  exp_t  e;
  string nm;

  always @(posedge osc) begin
    #1;
    while (q.size() > 0 && q[0].due <= cyc) begin
      e  = q.pop_front();
      nm = names.pop_front();
      checks++;
      if (e.due != cyc || bus.trim !== e.trim ||
          bus.locked !== e.locked || bus.fb_lost !== e.lost) begin
        errors++;
        $display("FAIL %s @%0d: trim=%h locked=%b fb_lost=%b, expected trim=%h locked=%b fb_lost=%b (due %0d)",
                 nm, cyc, bus.trim, bus.locked, bus.fb_lost,
                 e.trim, e.locked, e.lost, e.due);
      end
    end
  end

  function automatic logic [25:0] th(input int n);
    logic [63:0] v;
    v = (64'd1 << n) - 64'd1;
    return v[25:0];
  endfunction

  task automatic drive(input logic rst, input logic en, input logic d,
                       input logic fv, input logic [7:0] fc,
                       input logic [25:0] xt, input logic xl,
                       input logic xf, input string name);
    reset        = rst;
    bus.enable   = en;
    bus.dco      = d;
    bus.fb_valid = fv;
    bus.fb_count = fc;
    q.push_back('{due: cyc + 1, trim: xt, locked: xl, lost: xf});
    names.push_back(name);
    @(negedge osc);
  endtask

  task automatic idle(input int n);
    bus.fb_valid = 1'b0;
    repeat (n) @(negedge osc);
  endtask

  int up[8] = '{4, 8, 12, 16, 20, 24, 26, 26};
  int dn[5] = '{18, 14, 10, 6, 2};

  initial begin
    reset        = 1'b1;
    bus.enable   = 1'b1;
    bus.dco      = 1'b0;
    bus.div      = 5'd8;
    bus.ext_trim = '0;
    bus.fb_count = '0;
    bus.fb_valid = 1'b0;
    @(negedge osc);

    repeat (3) drive(1, 1, 0, 0, 0, 26'h0001FFF, 0, 0, "reset");
    repeat (3) drive(0, 1, 0, 0, 0, th(13), 0, 0, "reset_hold");

    drive(0, 1, 0, 1, 20, th(9), 0, 0, "coarse_dn");
    drive(0, 1, 0, 1, 10, th(8), 0, 0, "fine_dn");
    drive(0, 1, 0, 1, 30, th(4), 0, 0, "sat_low_a");
    drive(0, 1, 0, 1, 30, th(0), 0, 0, "sat_low_b");
    drive(0, 1, 0, 1, 30, th(0), 0, 0, "sat_low_hold");
    drive(0, 1, 0, 1, 2, th(4), 0, 0, "coarse_up_a");
    drive(0, 1, 0, 1, 2, th(8), 0, 0, "coarse_up_b");

    drive(0, 1, 0, 1, 8, th(8), 0, 0, "lock_w1");
    drive(0, 1, 0, 1, 10, th(7), 0, 0, "lock_miss");
    drive(0, 1, 0, 1, 8, th(7), 0, 0, "lock_w1b");
    drive(0, 1, 0, 1, 9, th(6), 0, 0, "lock_w2");
    drive(0, 1, 0, 1, 7, th(7), 0, 0, "lock_w3");
    drive(0, 1, 0, 1, 8, th(7), 1, 0, "lock_entry");
    drive(0, 1, 0, 1, 9, th(6), 1, 0, "locked_fine");
    drive(0, 1, 0, 1, 10, th(5), 1, 0, "locked_tol_edge");
    drive(0, 1, 0, 1, 20, th(4), 0, 0, "unlock_step1");
    drive(0, 1, 0, 1, 20, th(0), 0, 0, "acq_coarse");
    foreach (up[i]) drive(0, 1, 0, 1, 0, th(up[i]), 0, 0, "sat_high");

    bus.ext_trim = 26'h3FFFFFF;
    drive(0, 1, 1, 1, 30, 26'h3FFFFFF, 0, 0, "manual_enter");
    bus.ext_trim = 26'h0000ABC;
    drive(0, 1, 1, 1, 30, 26'h0000ABC, 0, 0, "manual_ext");
    drive(0, 1, 0, 0, 0, th(26), 0, 0, "manual_exit");
    drive(0, 1, 0, 1, 30, th(22), 0, 0, "post_manual");

    drive(0, 1, 0, 1, 8, th(22), 0, 0, "relock_1");
    drive(0, 1, 0, 1, 8, th(22), 0, 0, "relock_2");
    drive(0, 1, 0, 1, 8, th(22), 0, 0, "relock_3");
    drive(0, 1, 0, 1, 8, th(22), 1, 0, "relock_4");
    idle(1022);
    drive(0, 1, 0, 0, 0, th(22), 1, 0, "pre_timeout");
    drive(0, 1, 0, 0, 0, th(22), 0, 1, "timeout");
    drive(0, 1, 0, 1, 8, th(22), 0, 0, "lost_clear");

    bus.div = 5'd0;
    drive(0, 1, 0, 1, 30, th(22), 0, 0, "div_zero");
    bus.div = 5'd8;
    foreach (dn[i]) drive(0, 1, 0, 1, 30, th(dn[i]), 0, 0, "descend");
    drive(0, 1, 0, 1, 7, th(3), 0, 0, "code_3");

    drive(0, 0, 0, 0, 0, th(13), 0, 0, "enable_drop");
    drive(0, 1, 0, 0, 0, th(13), 0, 0, "idle_exit");
    drive(0, 1, 0, 1, 20, th(9), 0, 0, "reacquire");
    drive(1, 1, 0, 1, 30, th(13), 0, 0, "reset_with_fb");
    drive(0, 1, 0, 0, 0, th(13), 0, 0, "after_reset");
    drive(0, 1, 0, 1, 10, th(12), 0, 0, "fine_12");

    idle(3);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d pending, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
